// File: rtl/port_alloc_scheduler.sv
// port_alloc_scheduler
// Binds each accepted vector instruction to one of W_PORTS_NUM write-port
// groups, lends an idle group's odd read port for a third operand, and
// tracks a single outstanding store and a single outstanding load.
// Optional build macro: PORT_ALLOC_SKIP_BUSY_EN
//   defined   -> target is the first idle group at or after ptr_reg (wrapping)
//   undefined -> strict in-order target (ptr_reg); a busy group stalls and
//                the pointer steps forward one group per cycle
module port_alloc_scheduler #(
    parameter int W_PORTS_NUM = 4,
    localparam int PTR_W = (W_PORTS_NUM > 1) ? $clog2(W_PORTS_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [12:0]            instr_vld_i,
    output logic [12:0]            instr_rdy_o,
    input  logic                   vrf_starting_addr_vld_i,
    input  logic [W_PORTS_NUM-1:0] dependancy_issue_i,
    input  logic                   slide_instr_check_i,
    input  logic [W_PORTS_NUM-1:0] port_rdy_i,
    input  logic [W_PORTS_NUM-1:0] op3_rel_i,
    output logic [W_PORTS_NUM-1:0] start_o,
    output logic                   alloc_port_vld_o,
    output logic [PTR_W-1:0]       alloc_idx_o,
    output logic [PTR_W:0]         op3_port_sel_o,
    output logic                   op3_vld_o,
    output logic [PTR_W-1:0]       store_driver_o,
    output logic [PTR_W-1:0]       load_driver_o,
    output logic                   store_busy_o,
    output logic                   load_busy_o
);

    localparam int W = W_PORTS_NUM;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(W - 1);

    // Tracking state
    logic [PTR_W-1:0] ptr_reg;
    logic [W-1:0]     st_reg;
    logic [W-1:0]     ld_reg;
    logic [W-1:0]     op3_busy_reg;

    // Combinational decisions
    logic [W-1:0]     avail;
    logic [PTR_W-1:0] tgt;
    logic             tgt_ok;
    logic             dep_clear;
    logic             slide_wait;
    logic             rdy;
    logic [PTR_W-1:0] lend_idx;
    logic             lend_found;
    logic [12:0]      rdy_vec;
    logic             alloc;
    logic             launch;
    logic [W-1:0]     start_vec;
    logic [W-1:0]     lend_onehot;
    logic [PTR_W-1:0] st_drv;
    logic [PTR_W-1:0] ld_drv;
    logic             op3_take;
    logic             st_take;
    logic             ld_take;
    logic             st_done;
    logic             ld_done;
    logic [W-1:0]     op3_busy_next;

    // Config class only gates its own ready; it never launches a group.
    logic cfg_vld_unused;
    assign cfg_vld_unused = instr_vld_i[12];

    // A group can take work or lend its read port only when idle and not already lent.
    assign avail     = port_rdy_i & ~op3_busy_reg;
    assign dep_clear = (dependancy_issue_i == '0);

    // Target group selection; slides always execute on group 0.
    always_comb begin
        int cand;
        tgt  = ptr_reg;
        cand = 0;
`ifdef PORT_ALLOC_SKIP_BUSY_EN
        // Scan downward so the smallest offset from ptr_reg wins.
        for (int i = W - 1; i >= 0; i--) begin
            cand = int'(ptr_reg) + i;
            if (cand >= W) begin
                cand = cand - W;
            end
            if (avail[cand]) begin
                tgt = PTR_W'(cand);
            end
        end
`endif
        if (slide_instr_check_i) begin
            tgt = '0;
        end
    end

    // A slide waits until the pointer has been pulled back to group 0.
    assign slide_wait = slide_instr_check_i && (ptr_reg != '0);
    assign tgt_ok     = avail[tgt];
    assign rdy        = tgt_ok && dep_clear && !slide_wait;

    // Lowest idle, un-lent group other than the target lends its read port.
    always_comb begin
        lend_idx   = '0;
        lend_found = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if ((k != int'(tgt)) && avail[k]) begin
                lend_idx   = PTR_W'(k);
                lend_found = 1'b1;
            end
        end
    end

    // Per-class ready; loads yield to a store offered in the same cycle.
    always_comb begin
        rdy_vec        = '0;
        rdy_vec[0]     = rdy;
        rdy_vec[1]     = rdy && lend_found;
        rdy_vec[3:2]   = {2{rdy && (st_reg == '0)}};
        rdy_vec[5:4]   = {2{rdy && (ld_reg == '0) && (instr_vld_i[3:2] == 2'b00)}};
        rdy_vec[10:6]  = {5{rdy}};
        rdy_vec[11]    = port_rdy_i[0] && dep_clear;
        rdy_vec[12]    = (&port_rdy_i) && (start_vec == '0) && dep_clear &&
                         (st_reg == '0) && (ld_reg == '0) && (op3_busy_reg == '0);
    end

    assign alloc  = (|(instr_vld_i[11:0] & rdy_vec[11:0])) && vrf_starting_addr_vld_i;
    assign launch = alloc && rdy;

    // One-hot launch of the target and one-hot of the lending group.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_onehot
            assign start_vec[gi]   = launch && (tgt == PTR_W'(gi));
            assign lend_onehot[gi] = (lend_idx == PTR_W'(gi));
        end
    endgenerate

    // Encode the one-hot store/load owners; zero when nothing is outstanding.
    always_comb begin
        st_drv = '0;
        ld_drv = '0;
        for (int k = 0; k < W; k++) begin
            if (st_reg[k]) begin
                st_drv = PTR_W'(k);
            end
            if (ld_reg[k]) begin
                ld_drv = PTR_W'(k);
            end
        end
    end

    assign op3_take = launch && instr_vld_i[1] && rdy_vec[1];
    assign st_take  = launch && (|(instr_vld_i[3:2] & rdy_vec[3:2]));
    assign ld_take  = launch && (|(instr_vld_i[5:4] & rdy_vec[5:4]));
    // An owner is finished once its group is idle again and not being relaunched.
    assign st_done  = (st_reg != '0) && port_rdy_i[st_drv] && !start_vec[st_drv];
    assign ld_done  = (ld_reg != '0) && port_rdy_i[ld_drv] && !start_vec[ld_drv];
    // A release and a new loan on the same bit in one cycle leaves it lent.
    assign op3_busy_next = (op3_busy_reg & ~op3_rel_i) | (op3_take ? lend_onehot : '0);

    // Pointer, store/load owners and lent-port bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_reg      <= '0;
            st_reg       <= '0;
            ld_reg       <= '0;
            op3_busy_reg <= '0;
        end else begin
            if (launch) begin
                ptr_reg <= (tgt == LAST_IDX) ? '0 : tgt + 1'b1;
            end else if (slide_instr_check_i && (ptr_reg != '0)) begin
                ptr_reg <= '0;
            end
`ifndef PORT_ALLOC_SKIP_BUSY_EN
            else if (!tgt_ok) begin
                ptr_reg <= (ptr_reg == LAST_IDX) ? '0 : ptr_reg + 1'b1;
            end
`endif

            if (st_take) begin
                st_reg <= start_vec;
            end else if (st_done) begin
                st_reg <= '0;
            end

            if (ld_take) begin
                ld_reg <= start_vec;
            end else if (ld_done) begin
                ld_reg <= '0;
            end

            op3_busy_reg <= op3_busy_next;
        end
    end

    assign instr_rdy_o      = rdy_vec;
    assign start_o          = start_vec;
    assign alloc_port_vld_o = alloc;
    assign alloc_idx_o      = tgt;
    assign op3_port_sel_o   = {lend_idx, 1'b1};
    assign op3_vld_o        = lend_found;
    assign store_driver_o   = st_drv;
    assign load_driver_o    = ld_drv;
    assign store_busy_o     = (st_reg != '0);
    assign load_busy_o      = (ld_reg != '0);

endmodule

// File: tb/tb_port_alloc_scheduler.sv
// Bench for port_alloc_scheduler (W_PORTS_NUM = 4). Vectors are applied one
// per cycle; each vector's expected outputs go into a scoreboard queue when
// it is driven and are popped and compared on the following falling edge.
// Expectations that depend on PORT_ALLOC_SKIP_BUSY_EN select via SKIP.
module tb_port_alloc_scheduler;

`ifdef PORT_ALLOC_SKIP_BUSY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [12:0] instr_vld;
    logic [12:0] instr_rdy;
    logic        addr_vld;
    logic [3:0]  dep;
    logic        slide;
    logic [3:0]  prdy;
    logic [3:0]  rel;
    logic [3:0]  start;
    logic        alloc_vld;
    logic [1:0]  alloc_idx;
    logic [2:0]  op3_sel;
    logic        op3_vld;
    logic [1:0]  st_drv;
    logic [1:0]  ld_drv;
    logic        st_busy;
    logic        ld_busy;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    port_alloc_scheduler #(.W_PORTS_NUM(4)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .instr_vld_i             (instr_vld),
        .instr_rdy_o             (instr_rdy),
        .vrf_starting_addr_vld_i (addr_vld),
        .dependancy_issue_i      (dep),
        .slide_instr_check_i     (slide),
        .port_rdy_i              (prdy),
        .op3_rel_i               (rel),
        .start_o                 (start),
        .alloc_port_vld_o        (alloc_vld),
        .alloc_idx_o             (alloc_idx),
        .op3_port_sel_o          (op3_sel),
        .op3_vld_o               (op3_vld),
        .store_driver_o          (st_drv),
        .load_driver_o           (ld_drv),
        .store_busy_o            (st_busy),
        .load_busy_o             (ld_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [12:0] vld;
        logic        addr;
        logic [3:0]  dep;
        logic        slide;
        logic [3:0]  prdy;
        logic [3:0]  rel;
        logic [3:0]  e_start;
        logic        e_alloc;
        logic [1:0]  e_idx;
        logic [12:0] e_rdy;
        logic [2:0]  e_sel;
        logic        e_op3v;
        logic        e_stb;
        logic [1:0]  e_std;
        logic        e_ldb;
        logic [1:0]  e_ldd;
    } vec_t;

    vec_t table_q[$];
    vec_t hand_q[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic r, input logic [12:0] v, input logic a, input logic [3:0] d,
        input logic s, input logic [3:0] p, input logic [3:0] rl,
        input logic [3:0] es, input logic ea, input logic [1:0] ei, input logic [12:0] er,
        input logic [2:0] esel, input logic eov, input logic esb, input logic [1:0] esd,
        input logic elb, input logic [1:0] eld);
        vec_t t;
        t.rstn = r; t.vld = v; t.addr = a; t.dep = d; t.slide = s; t.prdy = p; t.rel = rl;
        t.e_start = es; t.e_alloc = ea; t.e_idx = ei; t.e_rdy = er; t.e_sel = esel;
        t.e_op3v = eov; t.e_stb = esb; t.e_std = esd; t.e_ldb = elb; t.e_ldd = eld;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %0h expected %0h", vec_no, name, act, exp);
        end
    endtask

    // Drive one vector just after the rising edge, check it on the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rstn      = v.rstn;
        instr_vld = v.vld;
        addr_vld  = v.addr;
        dep       = v.dep;
        slide     = v.slide;
        prdy      = v.prdy;
        rel       = v.rel;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        cmp("start_o",          16'(start),     16'(e.e_start));
        cmp("alloc_port_vld_o", 16'(alloc_vld), 16'(e.e_alloc));
        cmp("alloc_idx_o",      16'(alloc_idx), 16'(e.e_idx));
        cmp("instr_rdy_o",      16'(instr_rdy), 16'(e.e_rdy));
        cmp("op3_vld_o",        16'(op3_vld),   16'(e.e_op3v));
        if (e.e_op3v) cmp("op3_port_sel_o", 16'(op3_sel), 16'(e.e_sel));
        cmp("store_busy_o",     16'(st_busy),   16'(e.e_stb));
        cmp("store_driver_o",   16'(st_drv),    16'(e.e_std));
        cmp("load_busy_o",      16'(ld_busy),   16'(e.e_ldb));
        cmp("load_driver_o",    16'(ld_drv),    16'(e.e_ldd));
        $display("vec %0d rstn=%0b vld=%h prdy=%b start=%b idx=%0d rdy=%h st=%0b ld=%0b",
                 vec_no, v.rstn, v.vld, v.prdy, start, alloc_idx, instr_rdy, st_busy, ld_busy);
        vec_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; instr_vld = '0; addr_vld = 1'b0; dep = '0;
        slide = 1'b0; prdy = 4'hF; rel = '0;
        repeat (3) @(posedge clk);

        // Reset state, in-order rotation and wrap
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 13'h1FFF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0010, 1, 1, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0100, 1, 2, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b1000, 1, 3, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        // Busy group 1 with ptr=1: skip to group 2, or stall
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'b1101, 0, SKIP ? 4'b0100 : 4'b0000, SKIP,
                             SKIP ? 2'd2 : 2'd1, SKIP ? 13'h0FFF : 13'h0800, 1, 1, 0, 0, 0, 0));
        // Reset vector exposes the pointer reached above, then clears it
        table_q.push_back(mk(0, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd3 : 2'd2,
                             13'h1FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 0, 4'hF, 0, 4'b0010, 1, 1, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        // Store on group 2; group 2 busy, then idle -> store clears
        table_q.push_back(mk(1, 13'h004, 1, 0, 0, 4'hF, 0, 4'b0100, 1, 2, 13'h0FCF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'b1011, 0, 4'b0000, 0, 3, 13'h0FF3, 1, 1, 1, 2, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 3, 13'h0FF3, 1, 1, 1, 2, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 3, 13'h1FFF, 1, 1, 0, 0, 0, 0));
        // Load on group 3, second load blocked, then store beats load
        table_q.push_back(mk(1, 13'h010, 1, 0, 0, 4'hF, 0, 4'b1000, 1, 3, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h010, 1, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 13'h0FCF, 3, 1, 0, 0, 1, 3));
        table_q.push_back(mk(1, 13'h014, 1, 0, 0, 4'hF, 0, 4'b0001, 1, 0, 13'h0FCF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 1, 13'h0FF3, 1, 1, 1, 0, 0, 0));
        // Slide with ptr!=0 waits, pointer pulled to 0, then launches on group 0
        table_q.push_back(mk(1, 13'h001, 1, 0, 1, 4'hF, 0, 4'b0000, 0, 0, 13'h1800, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h001, 1, 0, 1, 4'hF, 0, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 1, 4'hF, 0, 4'b0000, 0, 0, 13'h1800, 3, 1, 0, 0, 0, 0));
        // op3 on group 0 borrows group 1 (sel 3), then released
        table_q.push_back(mk(1, 13'h002, 1, 0, 0, 4'hF, 0, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd2 : 2'd1,
                             SKIP ? 13'h0FFF : 13'h0800, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 4'b0010, 4'b0000, 0, 2, 13'h0FFF, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd1 : 2'd2,
                             13'h1FFF, 1, 1, 0, 0, 0, 0));
        // Dependency blocks everything; config ready when all idle
        table_q.push_back(mk(1, 13'h001, 1, 4'b0100, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd1 : 2'd2,
                             13'h0000, 1, 1, 0, 0, 0, 0));
        table_q.push_back(mk(1, 13'h1000, 1, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd1 : 2'd2,
                             13'h1FFF, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < table_q.size(); i++) begin
            apply(table_q[i]);
        end

        // Reset in the middle of an outstanding store
        hand_q.push_back(mk(1, 13'h004, 1, 0, 0, 4'hF, 0, SKIP ? 4'b0010 : 4'b0100, 1,
                            SKIP ? 2'd1 : 2'd2, 13'h0FCF, 1, 1, 0, 0, 0, 0));
        hand_q.push_back(mk(0, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd2 : 2'd3,
                            13'h0FF3, 1, 1, 1, SKIP ? 2'd1 : 2'd2, 0, 0));
        hand_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 0, 13'h1FFF, 3, 1, 0, 0, 0, 0));
        // No lender available: op3 class not ready, nothing launches
        hand_q.push_back(mk(1, 13'h002, 1, 0, 0, 4'b0001, 0, 4'b0000, 0, 0, 13'h0FFD, 0, 0, 0, 0, 0, 0));
        // Loan and release of the same port in one cycle: loan wins
        hand_q.push_back(mk(1, 13'h002, 1, 0, 0, 4'hF, 4'b0010, 4'b0001, 1, 0, 13'h0FFF, 3, 1, 0, 0, 0, 0));
        hand_q.push_back(mk(1, 13'h000, 0, 0, 0, 4'hF, 0, 4'b0000, 0, SKIP ? 2'd2 : 2'd1,
                            SKIP ? 13'h0FFF : 13'h0800, 1, 1, 0, 0, 0, 0));

        foreach (hand_q[i]) begin
            apply(hand_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
